// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC cosine core and its request scheduler.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP
  } state_t;

  localparam int unsigned CORDIC_DW          = 32;
  localparam int unsigned CORDIC_ITER        = 10;
  localparam int unsigned CORDIC_TIMEOUT_DEF = 32;

  // 1/K for the rotation gain, Q2.30
  localparam logic [31:0] CORDIC_GAIN_Q30 = 32'h26DD_3B6A;

  // atan(2^-i) in radians, Q2.30, one entry per iteration
  localparam logic [31:0] CORDIC_ATAN_Q30 [CORDIC_ITER] = '{
    32'h3243_F6A9, 32'h1DAC_6705, 32'h0FAD_BAFD, 32'h07F5_6EA7,
    32'h03FE_AB77, 32'h01FF_D55C, 32'h00FF_FAAB, 32'h007F_FF55,
    32'h003F_FFEB, 32'h001F_FFFD
  };

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above the
// pointer, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [2:0]      idx_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] pos;
  logic          found;

  // Scan upward from the pointer and grant the first requester seen
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    if (en_i) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        pos = IW'((32'(ptr_i) + k) % NREQ);
        if (!found && req_i[pos]) begin
          found        = 1'b1;
          grant_o[pos] = 1'b1;
          idx_o        = 3'(pos);
        end
      end
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one iterative CORDIC cosine core among NREQ requesters: round-robin
// grant, single launch, watchdog abort and a valid/ready response.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned DW      = CORDIC_DW,
  parameter int unsigned TIMEOUT = CORDIC_TIMEOUT_DEF,
  parameter int unsigned CW      = 6
) (
  input  logic               clock,
  input  logic               aclr_n,
  input  logic               clk_en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               resp_valid,
  output logic [2:0]         resp_id,
  output logic [DW-1:0]      resp_data,
  output logic               resp_err,
  input  logic               resp_ready,
  output logic               core_start,
  output logic [DW-1:0]      core_dataa,
  output logic               core_abort,
  input  logic               core_done,
  input  logic [DW-1:0]      core_result
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q;
  logic [2:0]      ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   dataa_q;
  logic [DW-1:0]   rdata_q;
  logic [2:0]      id_q;
  logic            err_q;
  logic            abort_q;

  logic            arb_en;
  logic [NREQ-1:0] grant;
  logic [2:0]      grant_idx;
  logic [DW-1:0]   grant_data;

  // Grants only exist in enabled, out-of-reset IDLE cycles, so req_ready
  // doubles as the accept pulse
  assign arb_en = aclr_n && clk_en && (state_q == IDLE);

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  // Select the winning operand from the packed request bus
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_data = req_data[i*DW +: DW];
    end
  end

  assign req_ready  = grant;
  assign core_start = (state_q == ISSUE);
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_data  = rdata_q;
  assign resp_err   = err_q;
  assign core_dataa = dataa_q;
  assign core_abort = abort_q;

  // Scheduler FSM with watchdog counter, operand/result latches and abort pulse
  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dataa_q <= '0;
      rdata_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else if (clk_en) begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|grant) begin
            dataa_q <= grant_data;
            id_q    <= grant_idx;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          // completion outranks a watchdog expiry in the same cycle
          if (core_done) begin
            rdata_q <= core_result;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            abort_q <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            ptr_q   <= (id_q == 3'(NREQ - 1)) ? '0 : id_q + 3'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cordic_scheduler.md
Name: cordic_scheduler

Overview:
- Shares one iterative CORDIC cosine core between NREQ requesters (e.g. two Nios II custom-instruction masters).
- Arbitrates requests round-robin, issues one IEEE-754 single-precision operand to the core and waits for its completion pulse.
- Returns the 32-bit result to the winning requester with a valid/ready handshake.
- A watchdog aborts the core if completion never arrives.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 32, operand/result width.
- TIMEOUT, 32, maximum cycles in BUSY before abort (must exceed core latency; core latency is 10).
- CW, 6, watchdog counter width (must satisfy 2^CW > TIMEOUT).

Ports:
- clock  in  1  system clock, all logic on rising edge
- aclr_n  in  1  reset, synchronous, active-low
- clk_en  in  1  global advance enable; when low all registers hold
- req_valid  in  NREQ  per-requester request
- req_data  in  NREQ*DW  operand for requester i in bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot accept pulse to the granted requester
- resp_valid  out  1  response available
- resp_id  out  3  index of the requester being answered
- resp_data  out  DW  CORDIC result (0 on error)
- resp_err  out  1  response is a timeout abort
- resp_ready  in  1  response consumed
- core_start  out  1  one-cycle launch pulse to the core
- core_dataa  out  DW  operand to the core, stable from ISSUE until the response is returned
- core_abort  out  1  one-cycle pulse that resets the core after a timeout
- core_done  in  1  one-cycle completion pulse from the core
- core_result  in  DW  core output, valid when core_done=1

Behaviour:
- Reset (aclr_n=0 at a clock edge, regardless of clk_en):
  - state=IDLE; rr pointer=0; counter=0.
  - All outputs 0.
  - Reset mid-operation drops the in-flight request silently; the core is reset by the same aclr_n.
- clk_en=0: state, pointer, counter and latches all freeze. Outputs are registered or state-decoded, so they hold their values. The core shares clk_en.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If any req_valid, grant the first set bit scanning upward from the pointer, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle.
  - Latch req_data[g] into core_dataa and g into resp_id; go to ISSUE.
  - No request: stay; req_ready=0.
- ISSUE: core_start=1 for exactly one enabled cycle; clear counter; go to BUSY.
- BUSY:
  - Counter increments each enabled cycle.
  - On core_done=1: latch core_result into resp_data, resp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: core_abort=1 for one cycle, resp_data=0, resp_err=1, go to RESP.
  - core_done and timeout in the same cycle: done wins, no abort.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err are stable.
  - On resp_ready=1: pointer=(g+1) mod NREQ, go to IDLE.
  - resp_ready while resp_valid=0 is ignored.
- Back-to-back: a new grant is possible in the cycle after the handshake completes (IDLE is one cycle minimum).
- Latency, with accept at cycle T and core latency L: core_start at T+1, core_done at T+1+L, resp_valid at T+2+L.
- core_done in IDLE, ISSUE or RESP is ignored (spurious) and does not alter state.
- req_valid deasserted by a requester before grant is not an error; only current req_valid is sampled.
- Fairness: each requester is granted at most once per NREQ grants while others are waiting.

Decomposition:
- Shared package cordic_pkg:
  - state enum (IDLE, ISSUE, BUSY, RESP);
  - CORDIC_DW=32, CORDIC_ITER=10, CORDIC_TIMEOUT_DEF=32;
  - fixed-point gain constant and angle table shared with the core.
- One sub-module: rr_arbiter.
  - Inputs: req, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Combinational, parameterised by NREQ.
- The FSM, watchdog counter and latches live in cordic_scheduler.

Test Plan:
- Core model with fixed 10-cycle latency returning operand^32'hFFFF_FFFF.
  - Single request req0=32'h3F80_0000 accepted at T.
  - Expect core_start at T+1, resp_valid at T+12, resp_id=0, resp_data=32'hC07F_FFFF, resp_err=0.
- Simultaneous req_valid=2'b11 held continuously, resp_ready tied 1: grants alternate 0,1,0,1; four responses with ids 0,1,0,1.
- Timeout:
  - Core never pulses done, TIMEOUT=32.
  - core_abort pulses exactly once, 32 cycles after entering BUSY.
  - Response resp_err=1, resp_data=0.
  - A following request completes normally.
- Backpressure: resp_ready held 0 for 20 cycles; resp_valid, resp_data and resp_id stay constant, req_ready stays 0 for a pending req1; grant to req1 occurs the cycle after resp_ready=1.
- clk_en=0 for 5 cycles during BUSY: counter and state freeze; response arrives exactly 5 cycles later than nominal.
- Reset during BUSY (aclr_n=0 for 1 cycle):
  - All outputs 0 next cycle, state IDLE, pointer 0.
  - A late core_done is ignored.
  - A new req1 is granted normally.
